pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register, the successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, ...). It carries an opaque `WIDTH`-bit payload across one stage boundary using a valid/ready handshake on both sides. A two-entry skid buffer keeps `o_pre_ready` registered while sustaining full throughput. Flush and bubble insertion are supported: a bubble is an inert NOP payload that still flows down the pipe and is flagged as such.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits; must be ≥ 1.
- `BUBBLE_VAL`, default `'0`: payload value driven for bubbles and for any empty slot.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `i_clk`, input, 1: single clock.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_flush`, input, 1: synchronous kill of all held and incoming beats.
- `i_bubble`, input, 1: replace the incoming beat's payload with `BUBBLE_VAL`.
- `i_pre_valid`, input, 1: upstream beat valid.
- `o_pre_ready`, output, 1: stage can accept a beat; registered.
- `i_pre_data`, input, `WIDTH`: upstream payload.
- `o_post_valid`, output, 1: downstream beat valid.
- `i_post_ready`, input, 1: downstream accepts.
- `o_post_data`, output, `WIDTH`: downstream payload.
- `o_post_bubble`, output, 1: the current output beat is a bubble.
- `o_stall_cnt`, output, `CNT_W`: count of cycles with `o_post_valid & !i_post_ready`; saturates at all-ones.

## Operation
- Handshake firing rules:
  - in-fire = `i_pre_valid & o_pre_ready`.
  - out-fire = `o_post_valid & i_post_ready`.
- Storage:
  - main register M drives the outputs.
  - skid register S holds overflow.
  - each slot stores `{bubble_flag, data}`.
- FSM states and transitions (priority: flush, then the table):
  - **EMPTY**: in-fire → ONE, M ← in.
  - **ONE**:
    - in & out → ONE, M ← in.
    - in & !out → TWO, S ← in.
    - !in & out → EMPTY.
  - **TWO**: out → ONE, M ← S. No input is accepted in TWO.
- Ready and valid:
  - `o_pre_ready` = registered (next_state != TWO).
  - `o_post_valid` = (state != EMPTY).
- Bubble insertion:
  - A beat accepted with `i_bubble=1` is stored as `{1, BUBBLE_VAL}`.
  - `i_bubble` without `i_pre_valid` has no effect.
- Flush:
  - `i_flush=1` → next state EMPTY, M and S ← `{0, BUBBLE_VAL}`.
  - A beat presented in the same cycle is discarded even if ready was high.
  - An out-fire in the same cycle still counts as delivered downstream.
- Empty-output rule: `o_post_data`=`BUBBLE_VAL` and `o_post_bubble`=0 whenever `o_post_valid`=0. Simulation trace compare relies on this.
- Stall counter: increments once per stalled cycle, saturates, and is cleared only by reset (flush does not clear it).

## Timing
- Reset values (asynchronous, immediate on `i_rst`):
  - state EMPTY, `o_pre_ready`=1, `o_post_valid`=0.
  - `o_post_data`=`BUBBLE_VAL`, `o_post_bubble`=0, `o_stall_cnt`=0.
- Latency: in-fire at cycle N → `o_post_valid` at N+1 when the stage was EMPTY.
- Throughput: 1 beat/cycle under continuous `i_post_ready`.
- Ready timing:
  - `o_pre_ready` drops the cycle after ONE→TWO.
  - it rises the cycle after TWO→ONE.
- No combinational path from `i_post_ready` to `o_pre_ready`.
- Ordering: beats leave strictly in acceptance order; S is never bypassed.
- Reset mid-transfer: all held beats are lost; no partial output.
- After a flush, `o_post_valid`=0 and `o_pre_ready`=1 in the next cycle.

## Structure
- Shared package `pipe_pkg`: `typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_e`.
- One natural sub-module: `pipe_skid_ctrl`. It holds the FSM, the ready register and the load enables for M and S. The data path stays in the top module.
- Existing fixed stage registers will be replaced by instances with `WIDTH` = concatenated stage bundle width.

## Test plan
All scenarios use `WIDTH=8` and `BUBBLE_VAL=8'h13`.
1. **Reset**: assert `i_rst` mid-cycle → outputs go immediately to valid 0, data 8'h13, ready 1, cnt 0.
2. **Stream**: push 0x01..0x10 back-to-back with `i_post_ready`=1 → same sequence out, each one cycle later, no ready drop.
3. **Backpressure**: push 0xA1, 0xA2, 0xA3 with `i_post_ready`=0 →
   - state TWO, ready 0 after 2 accepts, 0xA3 held upstream, cnt increments each cycle.
   - release → 0xA1, 0xA2, 0xA3 delivered in order.
4. **Bubble**: push 0x55 with `i_bubble`=1 → out data 8'h13, `o_post_bubble`=1.
5. **Flush in TWO**: present 0x77 with flush → valid 0 next cycle, 0x77 never appears, ready 1.
6. **Saturation**: `CNT_W=4`, stall for 20 cycles → cnt holds 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline stage register.
// The state encoding is shared so that debug tooling can decode the controller state.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_TWO
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipe_stage_skid boundary: upstream side, downstream side and sideband.
// The stage itself uses the slave view, and whoever drives the stage uses the master view.
interface pipe_stage_skid_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
);

  logic             i_flush;
  logic             i_bubble;
  logic             i_pre_valid;
  logic             o_pre_ready;
  logic [WIDTH-1:0] i_pre_data;
  logic             o_post_valid;
  logic             i_post_ready;
  logic [WIDTH-1:0] o_post_data;
  logic             o_post_bubble;
  logic [CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_flush, i_bubble, i_pre_valid, i_pre_data, i_post_ready,
    output o_pre_ready, o_post_valid, o_post_data, o_post_bubble, o_stall_cnt
  );

  modport master (
    output i_flush, i_bubble, i_pre_valid, i_pre_data, i_post_ready,
    input  o_pre_ready, o_post_valid, o_post_data, o_post_bubble, o_stall_cnt
  );

endinterface

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the two-entry skid stage. It produces the registered upstream ready
// and the load enables for the main (M) and skid (S) slots.
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic preValid_i,
  input  logic postReady_i,
  output logic preReady_o,
  output logic postValid_o,
  output logic loadMainIn_o,
  output logic loadMainSkid_o,
  output logic loadSkid_o,
  output logic clearSlots_o
);

  pipe_state_e state_q, state_d;
  logic        ready_q;
  logic        inFire;
  logic        outFire;

  assign inFire      = preValid_i & ready_q;
  assign outFire     = (state_q != PS_EMPTY) & postReady_i;
  assign preReady_o  = ready_q;
  assign postValid_o = (state_q != PS_EMPTY);

  // Flush overrides everything. S is only ever drained into M, never bypassed.
  always_comb begin
    state_d        = state_q;
    loadMainIn_o   = 1'b0;
    loadMainSkid_o = 1'b0;
    loadSkid_o     = 1'b0;
    clearSlots_o   = 1'b0;
    if (flush_i) begin
      state_d      = PS_EMPTY;
      clearSlots_o = 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (inFire) begin
            state_d      = PS_ONE;
            loadMainIn_o = 1'b1;
          end
        end
        PS_ONE: begin
          if (inFire && outFire) begin
            loadMainIn_o = 1'b1;
          end else if (inFire) begin
            state_d    = PS_TWO;
            loadSkid_o = 1'b1;
          end else if (outFire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (outFire) begin
            state_d        = PS_ONE;
            loadMainSkid_o = 1'b1;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // Ready is registered from the next state, which keeps i_post_ready off the upstream ready path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PS_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != PS_TWO);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a two-entry skid buffer, flush and bubble insertion.
// The control logic lives in pipe_skid_ctrl, and the payload slots and stall counter live here.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned           WIDTH      = 64,
  parameter logic [WIDTH-1:0]      BUBBLE_VAL = '0,
  parameter int unsigned           CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  pipe_stage_skid_if.slave bus
);

  typedef logic [WIDTH:0] slot_t;
  localparam slot_t            EMPTY_SLOT = {1'b0, BUBBLE_VAL};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            main_q, main_d;
  slot_t            skid_q, skid_d;
  slot_t            inSlot;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic             postValid;
  logic             preReady;
  logic             loadMainIn;
  logic             loadMainSkid;
  logic             loadSkid;
  logic             clearSlots;

  pipe_skid_ctrl u_ctrl (
    .clk_i          (i_clk),
    .rst_i          (i_rst),
    .flush_i        (bus.i_flush),
    .preValid_i     (bus.i_pre_valid),
    .postReady_i    (bus.i_post_ready),
    .preReady_o     (preReady),
    .postValid_o    (postValid),
    .loadMainIn_o   (loadMainIn),
    .loadMainSkid_o (loadMainSkid),
    .loadSkid_o     (loadSkid),
    .clearSlots_o   (clearSlots)
  );

  assign inSlot = bus.i_bubble ? {1'b1, BUBBLE_VAL} : {1'b0, bus.i_pre_data};

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    stallCnt_d = stallCnt_q;
    if (clearSlots) begin
      main_d = EMPTY_SLOT;
      skid_d = EMPTY_SLOT;
    end else begin
      if (loadMainSkid) begin
        main_d = skid_q;
      end else if (loadMainIn) begin
        main_d = inSlot;
      end
      if (loadSkid) begin
        skid_d = inSlot;
      end
    end
    if (postValid && !bus.i_post_ready && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      main_q     <= EMPTY_SLOT;
      skid_q     <= EMPTY_SLOT;
      stallCnt_q <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // A stale M is masked so that an idle output always reads as a plain BUBBLE_VAL non-bubble.
  assign bus.o_pre_ready   = preReady;
  assign bus.o_post_valid  = postValid;
  assign bus.o_post_data   = postValid ? main_q[WIDTH-1:0] : BUBBLE_VAL;
  assign bus.o_post_bubble = postValid & main_q[WIDTH];
  assign bus.o_stall_cnt   = stallCnt_q;

endmodule
